// File: rtl/lsu_access_ctrl_pkg.sv
// lsu_access_ctrl_pkg: shared instruction IDs, exception causes and load/store decode
package lsu_access_ctrl_pkg;

    localparam logic [5:0] INSTR_LB  = 6'd16;
    localparam logic [5:0] INSTR_LH  = 6'd17;
    localparam logic [5:0] INSTR_LW  = 6'd18;
    localparam logic [5:0] INSTR_LD  = 6'd19;
    localparam logic [5:0] INSTR_LBU = 6'd20;
    localparam logic [5:0] INSTR_LHU = 6'd21;
    localparam logic [5:0] INSTR_LWU = 6'd22;
    localparam logic [5:0] INSTR_SB  = 6'd24;
    localparam logic [5:0] INSTR_SH  = 6'd25;
    localparam logic [5:0] INSTR_SW  = 6'd26;
    localparam logic [5:0] INSTR_SD  = 6'd27;

    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_e;

    typedef struct packed {
        logic      is_load;
        logic      is_unsigned;
        mem_size_e size;
    } mem_op_t;

    // Doubleword accesses and LWU only exist on a 64-bit datapath.
    function automatic logic is_mem(input logic [5:0] id, input int data_w);
        case (id)
            INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
            INSTR_SB, INSTR_SH, INSTR_SW: return 1'b1;
            INSTR_LD, INSTR_LWU, INSTR_SD: return data_w == 64;
            default: return 1'b0;
        endcase
    endfunction

    function automatic mem_op_t decode_op(input logic [5:0] id);
        mem_op_t op;
        op.is_load     = id inside {INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LD, INSTR_LBU, INSTR_LHU, INSTR_LWU};
        op.is_unsigned = id inside {INSTR_LBU, INSTR_LHU, INSTR_LWU};
        op.size        = id inside {INSTR_LB, INSTR_LBU, INSTR_SB} ? SZ_B :
                         id inside {INSTR_LH, INSTR_LHU, INSTR_SH} ? SZ_H :
                         id inside {INSTR_LW, INSTR_LWU, INSTR_SW} ? SZ_W : SZ_D;
        return op;
    endfunction

endpackage

// File: rtl/lsu_access_ctrl_load_align.sv
// lsu_load_align: extracts a byte/half/word/double at a lane offset and sign/zero-extends it
module lsu_load_align
    import lsu_access_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int OFF_W = $clog2(DATA_W/8)
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF_W-1:0]  offset,
    input  mem_op_t           op,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic              sign;

    // The top bit of the mask marks the sign bit of the selected field.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        mask    = ~({DATA_W{1'b1}} << (7'd8 << op.size));
        sign    = !op.is_unsigned && |(shifted & mask & ~(mask >> 1));
        data    = (shifted & mask) | (sign ? ~mask : '0);
    end

endmodule

// File: rtl/lsu_access_ctrl.sv
// lsu_access_ctrl: single-outstanding load/store unit between MEM stage and data memory
module lsu_access_ctrl
    import lsu_access_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    output logic                ready_out,
    input  logic [5:0]          instr_id,
    input  logic [TAG_W-1:0]    rd_in,
    input  logic [DATA_W-1:0]   rs2_value,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic                flush,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_be,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [TAG_W-1:0]    out_rd,
    output logic                out_is_load,
    output logic                exc_valid,
    output logic [3:0]          exc_cause,
    output logic                stall
);

    localparam int BE_W  = DATA_W/8;
    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_EXC} state_e;

    state_e            state, state_nxt;
    mem_op_t           op_in, op_q;
    logic              accept, misaligned, drop_q;
    logic [OFF_W-1:0]  off_in, off_q;
    logic [TAG_W-1:0]  rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] size_mask, wdata_in, wdata_q, ext_data, data_q;
    logic [BE_W-1:0]   be_in, be_q;

    always_comb begin
        op_in      = decode_op(instr_id);
        off_in     = mem_addr[OFF_W-1:0];
        accept     = state == S_IDLE && valid_in && is_mem(instr_id, DATA_W) && !flush;
        misaligned = |(off_in & OFF_W'((1 << op_in.size) - 1));
        size_mask  = ~({DATA_W{1'b1}} << (7'd8 << op_in.size));
        wdata_in   = (rs2_value & size_mask) << {off_in, 3'b000};
        be_in      = ~({BE_W{1'b1}} << (4'd1 << op_in.size)) << off_in;
    end

    lsu_load_align #(.DATA_W(DATA_W)) u_load_align (
        .rdata  (mem_rsp_rdata),
        .offset (off_q),
        .op     (op_q),
        .data   (ext_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // A grant that coincides with a flush has already reached memory: a load must
    // still drain its response (dropped), a store simply completes silently.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = accept ? (misaligned ? S_EXC : S_REQ) : S_IDLE;
            S_REQ:   state_nxt = mem_req_ready ? (op_q.is_load ? S_WAIT : (flush ? S_IDLE : S_DONE)) :
                                 flush ? S_IDLE : S_REQ;
            S_WAIT:  state_nxt = !mem_rsp_valid ? S_WAIT : (drop_q || flush) ? S_IDLE : S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= '0;
            off_q   <= '0;
            rd_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            data_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= op_in;
                off_q   <= off_in;
                rd_q    <= rd_in;
                addr_q  <= {mem_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                wdata_q <= wdata_in;
                be_q    <= be_in;
                data_q  <= '0;
            end
            if (state == S_WAIT && mem_rsp_valid) data_q <= ext_data;
            drop_q <= state_nxt == S_WAIT && (drop_q || flush);
        end
    end

    always_comb begin
        ready_out     = state == S_IDLE;
        stall         = valid_in && state != S_IDLE;
        mem_req_valid = state == S_REQ;
        mem_req_we    = mem_req_valid && !op_q.is_load;
        mem_req_addr  = mem_req_valid ? addr_q : '0;
        mem_req_wdata = mem_req_we ? wdata_q : '0;
        mem_req_be    = mem_req_valid ? be_q : '0;
        out_valid     = state == S_DONE || state == S_EXC;
        exc_valid     = state == S_EXC;
        out_data      = state == S_DONE ? data_q : '0;
        out_rd        = out_valid ? rd_q : '0;
        out_is_load   = out_valid && op_q.is_load;
        exc_cause     = exc_valid ? (op_q.is_load ? EXC_LD_MISALIGN : EXC_ST_MISALIGN) : 4'd0;
    end

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// tb_lsu_access_ctrl: directed checks of the LSU on 32- and 64-bit datapaths
module tb_lsu_access_ctrl;
    import lsu_access_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_valid_in = 0, a_flush = 0, a_req_ready = 1, a_rsp_valid = 0;
    logic [5:0]  a_instr = 0;
    logic [4:0]  a_rd = 0;
    logic [31:0] a_rs2 = 0, a_addr = 0, a_rdata = 0;
    logic        a_ready_out, a_req_valid, a_req_we, a_out_valid, a_out_is_load, a_exc_valid, a_stall;
    logic [31:0] a_req_addr, a_req_wdata, a_out_data;
    logic [3:0]  a_req_be, a_exc_cause;
    logic [4:0]  a_out_rd;

    logic        b_valid_in = 0, b_flush = 0, b_req_ready = 1, b_rsp_valid = 0;
    logic [5:0]  b_instr = 0;
    logic [4:0]  b_rd = 0;
    logic [63:0] b_rs2 = 0, b_rdata = 0;
    logic [31:0] b_addr = 0;
    logic        b_ready_out, b_req_valid, b_req_we, b_out_valid, b_out_is_load, b_exc_valid, b_stall;
    logic [31:0] b_req_addr;
    logic [63:0] b_req_wdata, b_out_data;
    logic [7:0]  b_req_be;
    logic [3:0]  b_exc_cause;
    logic [4:0]  b_out_rd;

    lsu_access_ctrl #(.DATA_W(32)) dut32 (
        .clk(clk), .rst(rst), .valid_in(a_valid_in), .ready_out(a_ready_out), .instr_id(a_instr),
        .rd_in(a_rd), .rs2_value(a_rs2), .mem_addr(a_addr), .flush(a_flush),
        .mem_req_valid(a_req_valid), .mem_req_ready(a_req_ready), .mem_req_we(a_req_we),
        .mem_req_addr(a_req_addr), .mem_req_wdata(a_req_wdata), .mem_req_be(a_req_be),
        .mem_rsp_valid(a_rsp_valid), .mem_rsp_rdata(a_rdata), .out_valid(a_out_valid),
        .out_data(a_out_data), .out_rd(a_out_rd), .out_is_load(a_out_is_load),
        .exc_valid(a_exc_valid), .exc_cause(a_exc_cause), .stall(a_stall)
    );

    lsu_access_ctrl #(.DATA_W(64)) dut64 (
        .clk(clk), .rst(rst), .valid_in(b_valid_in), .ready_out(b_ready_out), .instr_id(b_instr),
        .rd_in(b_rd), .rs2_value(b_rs2), .mem_addr(b_addr), .flush(b_flush),
        .mem_req_valid(b_req_valid), .mem_req_ready(b_req_ready), .mem_req_we(b_req_we),
        .mem_req_addr(b_req_addr), .mem_req_wdata(b_req_wdata), .mem_req_be(b_req_be),
        .mem_rsp_valid(b_rsp_valid), .mem_rsp_rdata(b_rdata), .out_valid(b_out_valid),
        .out_data(b_out_data), .out_rd(b_out_rd), .out_is_load(b_out_is_load),
        .exc_valid(b_exc_valid), .exc_cause(b_exc_cause), .stall(b_stall)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int a_ov    = 0;
    int ov0     = 0;

    always @(negedge clk) if (a_out_valid) a_ov++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store32(input string tag, input logic [5:0] instr, input logic [31:0] addr,
                           input logic [31:0] rs2, input logic [3:0] be, input logic [31:0] wdata);
        a_valid_in = 1; a_instr = instr; a_rd = 5'd3; a_addr = addr; a_rs2 = rs2;
        tick();
        a_valid_in = 0;
        chk({tag, "_req_valid"}, a_req_valid, 1);
        chk({tag, "_we"}, a_req_we, 1);
        chk({tag, "_addr"}, a_req_addr, {addr[31:2], 2'b00});
        chk({tag, "_be"}, a_req_be, be);
        chk({tag, "_wdata"}, a_req_wdata, wdata);
        chk({tag, "_early"}, a_out_valid, 0);
        tick();
        chk({tag, "_out_valid"}, a_out_valid, 1);
        chk({tag, "_exc"}, a_exc_valid, 0);
        chk({tag, "_out_data"}, a_out_data, 0);
        chk({tag, "_out_rd"}, a_out_rd, 3);
        chk({tag, "_is_load"}, a_out_is_load, 0);
        tick();
        chk({tag, "_pulse"}, a_out_valid, 0);
    endtask

    task automatic load32(input string tag, input logic [5:0] instr, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
        a_valid_in = 1; a_instr = instr; a_rd = 5'd7; a_addr = addr;
        tick();
        a_valid_in = 0;
        chk({tag, "_req_valid"}, a_req_valid, 1);
        chk({tag, "_we"}, a_req_we, 0);
        chk({tag, "_addr"}, a_req_addr, {addr[31:2], 2'b00});
        tick();
        chk({tag, "_wait"}, a_req_valid | a_out_valid, 0);
        a_rsp_valid = 1; a_rdata = rdata;
        tick();
        a_rsp_valid = 0;
        chk({tag, "_out_valid"}, a_out_valid, 1);
        chk({tag, "_out_data"}, a_out_data, exp);
        chk({tag, "_out_rd"}, a_out_rd, 7);
        chk({tag, "_is_load"}, a_out_is_load, 1);
        chk({tag, "_exc"}, a_exc_valid, 0);
        tick();
    endtask

    task automatic exc32(input string tag, input logic [5:0] instr, input logic [31:0] addr,
                         input logic [3:0] cause);
        a_valid_in = 1; a_instr = instr; a_rd = 5'd5; a_addr = addr;
        tick();
        a_valid_in = 0;
        chk({tag, "_no_req"}, a_req_valid, 0);
        chk({tag, "_out_valid"}, a_out_valid, 1);
        chk({tag, "_exc_valid"}, a_exc_valid, 1);
        chk({tag, "_cause"}, a_exc_cause, cause);
        chk({tag, "_out_data"}, a_out_data, 0);
        tick();
        chk({tag, "_pulse"}, a_out_valid | a_exc_valid, 0);
    endtask

    task automatic load64(input string tag, input logic [5:0] instr, input logic [31:0] addr,
                          input logic [63:0] rdata, input logic [63:0] exp);
        b_valid_in = 1; b_instr = instr; b_rd = 5'd11; b_addr = addr;
        tick();
        b_valid_in = 0;
        chk({tag, "_addr"}, b_req_addr, {addr[31:3], 3'b000});
        tick();
        b_rsp_valid = 1; b_rdata = rdata;
        tick();
        b_rsp_valid = 0;
        chk({tag, "_out_valid"}, b_out_valid, 1);
        chk({tag, "_out_data"}, b_out_data, exp);
        tick();
    endtask

    initial begin
        #2 rst = 0;
        tick(); tick();
        chk("rst_ready", a_ready_out, 1);
        chk("rst_outs", {a_req_valid, a_out_valid, a_exc_valid, a_stall, a_req_we}, 0);
        chk("rst_data", a_out_data | a_req_addr | a_req_wdata, 0);
        chk("rst_ready64", b_ready_out, 1);
        rst = 1;
        tick();

        store32("sb", INSTR_SB, 32'h1003, 32'h0000_00A5, 4'b1000, 32'hA500_0000);
        store32("sh", INSTR_SH, 32'h3002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_0000);
        store32("sw", INSTR_SW, 32'h3000, 32'h1234_5678, 4'b1111, 32'h1234_5678);

        load32("lh",  INSTR_LH,  32'h2002, 32'h8001_1234, 32'hFFFF_8001);
        load32("lhu", INSTR_LHU, 32'h2002, 32'h8001_1234, 32'h0000_8001);
        load32("lb",  INSTR_LB,  32'h6001, 32'h0000_F000, 32'hFFFF_FFF0);
        load32("lbu", INSTR_LBU, 32'h6001, 32'h0000_F000, 32'h0000_00F0);
        load32("lw",  INSTR_LW,  32'h6000, 32'h8000_0001, 32'h8000_0001);

        exc32("sw_mis", INSTR_SW, 32'h3002, EXC_ST_MISALIGN);
        exc32("lw_mis", INSTR_LW, 32'h3001, EXC_LD_MISALIGN);
        exc32("lh_mis", INSTR_LH, 32'h2003, EXC_LD_MISALIGN);
        exc32("sh_mis", INSTR_SH, 32'h2001, EXC_ST_MISALIGN);

        // back-pressured load with a two-cycle response
        ov0 = a_ov;
        a_req_ready = 0; a_valid_in = 1; a_instr = INSTR_LW; a_rd = 5'd9; a_addr = 32'h5004;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("bp_req_valid", a_req_valid, 1);
            chk("bp_addr", a_req_addr, 32'h5004);
            chk("bp_be", a_req_be, 4'hF);
            chk("bp_stall", a_stall, 1);
            chk("bp_ready", a_ready_out, 0);
            tick();
        end
        a_req_ready = 1;
        #1 chk("bp_grant_addr", a_req_addr, 32'h5004);
        tick();
        chk("bp_wait_stall", a_stall, 1);
        chk("bp_wait_req", a_req_valid, 0);
        tick();
        a_rsp_valid = 1; a_rdata = 32'h1122_3344;
        chk("bp_wait2_ready", a_ready_out, 0);
        tick();
        a_rsp_valid = 0;
        chk("bp_out_valid", a_out_valid, 1);
        chk("bp_out_data", a_out_data, 32'h1122_3344);
        chk("bp_out_rd", a_out_rd, 9);
        chk("bp_done_stall", a_stall, 1);
        a_valid_in = 0;
        tick(); tick();
        chk("bp_one_pulse", a_ov - ov0, 1);

        // flush while the request is pending
        ov0 = a_ov;
        a_req_ready = 0; a_valid_in = 1; a_instr = INSTR_LW; a_addr = 32'h5008;
        tick();
        a_valid_in = 0;
        chk("fr_req", a_req_valid, 1);
        a_flush = 1;
        tick();
        a_flush = 0; a_req_ready = 1;
        chk("fr_withdrawn", a_req_valid, 0);
        chk("fr_ready", a_ready_out, 1);
        tick(); tick();
        chk("fr_no_out", a_ov - ov0, 0);

        // flush while waiting: response drained, completion suppressed
        ov0 = a_ov;
        a_valid_in = 1; a_instr = INSTR_LW; a_addr = 32'h500C;
        tick();
        a_valid_in = 0;
        tick();
        a_flush = 1;
        tick();
        a_flush = 0;
        chk("fw_still_wait", a_ready_out, 0);
        a_rsp_valid = 1; a_rdata = 32'hCAFE_F00D;
        tick();
        a_rsp_valid = 0;
        chk("fw_ready", a_ready_out, 1);
        tick();
        chk("fw_no_out", a_ov - ov0, 0);
        load32("fw_next", INSTR_LHU, 32'h6002, 32'h7654_0000, 32'h0000_7654);

        // ignored inputs in IDLE
        a_valid_in = 1; a_instr = 6'd0;
        #1 chk("nonmem_stall", a_stall, 0);
        tick();
        chk("nonmem_idle", {a_ready_out, a_req_valid, a_out_valid}, 3'b100);
        a_instr = INSTR_LD;
        tick();
        chk("ld32_idle", {a_ready_out, a_req_valid, a_out_valid}, 3'b100);
        a_instr = INSTR_SB; a_addr = 32'h1000; a_flush = 1;
        tick();
        chk("flush_idle", {a_ready_out, a_req_valid, a_out_valid}, 3'b100);
        a_flush = 0; a_valid_in = 0;
        tick();

        // 64-bit datapath
        b_valid_in = 1; b_instr = INSTR_SD; b_rd = 5'd4; b_addr = 32'h4000; b_rs2 = 64'h0123_4567_89AB_CDEF;
        tick();
        b_valid_in = 0;
        chk("sd_be", b_req_be, 8'hFF);
        chk("sd_wdata", b_req_wdata, 64'h0123_4567_89AB_CDEF);
        chk("sd_addr", b_req_addr, 32'h4000);
        tick();
        chk("sd_out", {b_out_valid, b_exc_valid}, 2'b10);
        chk("sd_out_rd", b_out_rd, 4);
        tick();

        b_valid_in = 1; b_instr = INSTR_SW; b_addr = 32'h4004; b_rs2 = 64'hFFFF_FFFF_1357_9BDF;
        tick();
        b_valid_in = 0;
        chk("sw64_be", b_req_be, 8'hF0);
        chk("sw64_wdata", b_req_wdata, 64'h1357_9BDF_0000_0000);
        tick(); tick();

        load64("lwu64", INSTR_LWU, 32'h4004, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF);
        load64("lw64",  INSTR_LW,  32'h4004, 64'hDEAD_BEEF_0000_0000, 64'hFFFF_FFFF_DEAD_BEEF);
        load64("ld64",  INSTR_LD,  32'h4008, 64'h8877_6655_4433_2211, 64'h8877_6655_4433_2211);

        b_valid_in = 1; b_instr = INSTR_LD; b_addr = 32'h4004;
        tick();
        b_valid_in = 0;
        chk("ld64_mis", {b_req_valid, b_out_valid, b_exc_valid}, 3'b011);
        chk("ld64_cause", b_exc_cause, EXC_LD_MISALIGN);
        tick();

        // reset in the middle of a wait
        b_valid_in = 1; b_instr = INSTR_LD; b_addr = 32'h4010;
        tick();
        b_valid_in = 0;
        tick();
        chk("rw_in_wait", b_ready_out, 0);
        rst = 0;
        #1;
        chk("rw_ready", b_ready_out, 1);
        chk("rw_outs", {b_req_valid, b_out_valid, b_exc_valid, b_stall}, 0);
        chk("rw_data", b_out_data | b_req_wdata, 0);
        rst = 1;
        b_rsp_valid = 1; b_rdata = 64'h1;
        tick();
        b_rsp_valid = 0;
        chk("rw_rsp_ignored", {b_out_valid, b_ready_out}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
